// File: rtl/mips_mem_pkg.sv
// Shared MIPS data-memory encodings: mem_op codes, bus size codes and
// the dmem_ctrl FSM state encoding, plus small decode helpers.
package mips_mem_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } mem_op_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } dmem_state_e;

  function automatic logic op_is_load(input mem_op_e op);
    return (op <= OP_LW);
  endfunction

  function automatic logic [1:0] op_size(input mem_op_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
      default:              return SIZE_WORD;
    endcase
  endfunction

  function automatic logic op_misaligned(input mem_op_e op, input logic [1:0] lo);
    case (op_size(op))
      SIZE_HALF: return lo[0];
      SIZE_WORD: return (lo != 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Execute-stage request/response plus data-bus signals of dmem_ctrl.
// slave = the controller, master = pipeline and memory bus side.
interface dmem_ctrl_if;
  logic        req_valid;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        addr_err;
  logic        d_req;
  logic        d_wr;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_addr_ok;
  logic        d_data_ok;
  logic [31:0] d_rdata;

  modport slave (
    input  req_valid, mem_op, addr, wdata, d_addr_ok, d_data_ok, d_rdata,
    output stall, rdata, rdata_valid, addr_err,
           d_req, d_wr, d_size, d_addr, d_wdata, d_wstrb
  );

  modport master (
    output req_valid, mem_op, addr, wdata, d_addr_ok, d_data_ok, d_rdata,
    input  stall, rdata, rdata_valid, addr_err,
           d_req, d_wr, d_size, d_addr, d_wdata, d_wstrb
  );
endinterface

// File: rtl/dmem_load_align.sv
// Load lane select and sign/zero extension, little-endian; purely combinational.
module dmem_load_align
  import mips_mem_pkg::*;
(
  input  mem_op_e     i_op,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_lane)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_data = i_word;
    case (i_op)
      OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_data = {24'd0, w_byte};
      OP_LH:   o_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MIPS data-memory controller: accept -> REQ (d_req) -> optional WAIT -> DONE, min 2 cycles to rdata_valid;
// stalls upstream until DONE. DMEM_ALIGN_CHECK_EN enables misalignment trapping via addr_err.
module dmem_ctrl
  import mips_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  dmem_ctrl_if.slave dif
);

  dmem_state_e r_state;
  dmem_state_e w_next;
  mem_op_e     r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  mem_op_e     w_req_op;
  logic        w_misalign;
  logic        w_accept;
  logic        w_is_load;
  logic        w_data_hit;
  logic [31:0] w_load_data;
  logic [3:0]  w_strb;
  logic [31:0] w_wdat;
  logic [31:0] w_daddr;

  assign w_req_op = mem_op_e'(dif.mem_op);

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misalign = op_misaligned(w_req_op, dif.addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept   = (r_state == ST_IDLE) && dif.req_valid && !w_misalign;
  assign w_is_load  = op_is_load(r_op);
  // Responses only count while a request is actually in flight.
  assign w_data_hit = ((r_state == ST_REQ) && dif.d_addr_ok && dif.d_data_ok) ||
                      ((r_state == ST_WAIT) && dif.d_data_ok);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    dif.stall       = 1'b0;
    dif.d_req       = 1'b0;
    dif.rdata_valid = 1'b0;
    dif.addr_err    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        dif.stall    = w_accept;
        dif.addr_err = dif.req_valid && w_misalign;
        if (w_accept) w_next = ST_REQ;
      end
      ST_REQ: begin
        dif.d_req = 1'b1;
        dif.stall = 1'b1;
        if (dif.d_addr_ok) w_next = dif.d_data_ok ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        dif.stall = 1'b1;
        if (dif.d_data_ok) w_next = ST_DONE;
      end
      ST_DONE: begin
        dif.rdata_valid = w_is_load;
        w_next          = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_op    <= OP_LB;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      if (w_accept) begin
        r_op    <= w_req_op;
        r_addr  <= dif.addr;
        r_wdata <= dif.wdata;
      end
      if (w_data_hit && w_is_load) r_rdata <= w_load_data;
    end
  end

  dmem_load_align u_load_align (
    .i_op   (r_op),
    .i_lane (r_addr[1:0]),
    .i_word (dif.d_rdata),
    .o_data (w_load_data)
  );

  always_comb begin
    w_strb  = 4'b0000;
    w_wdat  = r_wdata;
    w_daddr = r_addr;
    case (r_op)
      OP_SB: begin
        w_strb = 4'b0001 << r_addr[1:0];
        w_wdat = {4{r_wdata[7:0]}};
      end
      OP_SH: begin
        w_strb = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdat = {2{r_wdata[15:0]}};
      end
      OP_SW:   w_strb = 4'b1111;
      default: w_strb = 4'b0000;
    endcase
`ifndef DMEM_ALIGN_CHECK_EN
    // Without trapping, misaligned low bits are simply dropped.
    case (op_size(r_op))
      SIZE_HALF: w_daddr[0]   = 1'b0;
      SIZE_WORD: w_daddr[1:0] = 2'b00;
      default:   w_daddr      = r_addr;
    endcase
`endif
  end

  assign dif.d_wr    = (r_state == ST_REQ) && !w_is_load;
  assign dif.d_wstrb = (r_state == ST_REQ) ? w_strb : 4'b0000;
  assign dif.d_size  = op_size(r_op);
  assign dif.d_addr  = w_daddr;
  assign dif.d_wdata = w_wdat;
  assign dif.rdata   = r_rdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed loads/stores, response delays,
// alignment handling, reset mid-transaction and a randomized load scoreboard.
module tb_dmem_ctrl;
  import mips_mem_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dmem_ctrl_if dif ();

  dmem_ctrl u_dut (
    .clk  (clk),
    .rstn (rstn),
    .dif  (dif)
  );

  int n_chk = 0;
  int n_err = 0;
  int cnt_stall = 0;
  int cnt_dreq = 0;
  int cnt_rv = 0;
  logic [31:0] sb_q[$];

  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_raw;
  logic [1:0]  r_sz;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [1:0] lo,
                                            input logic [31:0] w);
    logic [31:0] sb;
    logic [31:0] sh;
    int bs;
    int hs;
    bs = int'(lo) * 8;
    hs = int'(lo[1]) * 16;
    sb = w >> bs;
    sh = w >> hs;
    case (op)
      3'd0:    return {{24{sb[7]}}, sb[7:0]};
      3'd1:    return {24'd0, sb[7:0]};
      3'd2:    return {{16{sh[15]}}, sh[15:0]};
      3'd3:    return {16'd0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // Scoreboard consumer and activity counters.
  always @(negedge clk) begin
    if (dif.stall === 1'b1) cnt_stall++;
    if (dif.d_req === 1'b1) cnt_dreq++;
    if (dif.rdata_valid === 1'b1) begin
      cnt_rv++;
      if (sb_q.size() == 0) check_eq("rv_unexpected", 32'd1, 32'd0);
      else check_eq("rdata", dif.rdata, sb_q.pop_front());
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int aw, input int dw,
                       input logic [31:0] e_addr, input logic [31:0] e_wdata,
                       input logic [3:0] e_strb, input logic [1:0] e_size,
                       input logic [31:0] e_rdata);
    int s0, q0, v0;
    logic ld;
    ld = (op <= 3'd4);
    s0 = cnt_stall;
    q0 = cnt_dreq;
    v0 = cnt_rv;
    if (ld) sb_q.push_back(e_rdata);
    @(posedge clk); #1;
    dif.req_valid = 1'b1; dif.mem_op = op; dif.addr = a; dif.wdata = wd; dif.d_rdata = rd;
    @(negedge clk);
    check_eq("acc_stall", dif.stall, 32'd1);
    check_eq("acc_dreq", dif.d_req, 32'd0);
    check_eq("acc_err", dif.addr_err, 32'd0);
    @(posedge clk); #1;
    // A new request while busy must be ignored.
    dif.req_valid = 1'b1; dif.mem_op = 3'd7; dif.addr = 32'hFFFF_FFF0; dif.wdata = 32'h1111_2222;
    for (int i = 0; i <= aw; i++) begin
      dif.d_addr_ok = (i == aw);
      dif.d_data_ok = (i == aw) && (dw == 0);
      @(negedge clk);
      check_eq("req_dreq", dif.d_req, 32'd1);
      check_eq("req_stall", dif.stall, 32'd1);
      check_eq("req_addr", dif.d_addr, e_addr);
      check_eq("req_wr", dif.d_wr, {31'd0, !ld});
      check_eq("req_strb", dif.d_wstrb, e_strb);
      check_eq("req_size", dif.d_size, e_size);
      if (!ld) check_eq("req_wdata", dif.d_wdata, e_wdata);
      @(posedge clk); #1;
    end
    dif.d_addr_ok = 1'b0;
    dif.d_data_ok = 1'b0;
    for (int i = 1; i <= dw; i++) begin
      dif.d_data_ok = (i == dw);
      @(negedge clk);
      check_eq("wait_dreq", dif.d_req, 32'd0);
      check_eq("wait_stall", dif.stall, 32'd1);
      @(posedge clk); #1;
    end
    dif.d_data_ok = 1'b0;
    dif.req_valid = 1'b0;
    @(negedge clk);
    check_eq("done_rv", dif.rdata_valid, {31'd0, ld});
    check_eq("done_stall", dif.stall, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("idle_stall", dif.stall, 32'd0);
    check_eq("n_stall", cnt_stall - s0, 2 + aw + dw);
    check_eq("n_dreq", cnt_dreq - q0, aw + 1);
    check_eq("n_rv", cnt_rv - v0, {31'd0, ld});
  endtask

`ifdef DMEM_ALIGN_CHECK_EN
  task automatic do_misalign(input logic [2:0] op, input logic [31:0] a);
    int q0;
    q0 = cnt_dreq;
    @(posedge clk); #1;
    dif.req_valid = 1'b1; dif.mem_op = op; dif.addr = a;
    @(negedge clk);
    check_eq("mis_err", dif.addr_err, 32'd1);
    check_eq("mis_stall", dif.stall, 32'd0);
    @(posedge clk); #1;
    dif.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("mis_err_off", dif.addr_err, 32'd0);
      check_eq("mis_stall_off", dif.stall, 32'd0);
      @(posedge clk); #1;
    end
    check_eq("mis_dreq", cnt_dreq - q0, 32'd0);
  endtask
`endif

  initial begin
    dif.req_valid = 1'b0; dif.mem_op = 3'd0; dif.addr = 32'd0; dif.wdata = 32'd0;
    dif.d_addr_ok = 1'b0; dif.d_data_ok = 1'b0; dif.d_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", dif.stall, 32'd0);
    check_eq("rst_dreq", dif.d_req, 32'd0);
    check_eq("rst_wr", dif.d_wr, 32'd0);
    check_eq("rst_strb", dif.d_wstrb, 32'd0);
    check_eq("rst_rv", dif.rdata_valid, 32'd0);
    check_eq("rst_err", dif.addr_err, 32'd0);
    check_eq("rst_rdata", dif.rdata, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    do_op(3'd4, 32'h100, 32'd0, 32'hDEAD_BEEF, 0, 0, 32'h100, 32'd0, 4'b0000, 2'd2, 32'hDEAD_BEEF);
    do_op(3'd0, 32'h103, 32'd0, 32'h8011_2233, 0, 0, 32'h103, 32'd0, 4'b0000, 2'd0, 32'hFFFF_FF80);
    do_op(3'd1, 32'h103, 32'd0, 32'h8011_2233, 0, 1, 32'h103, 32'd0, 4'b0000, 2'd0, 32'h0000_0080);
    do_op(3'd2, 32'h102, 32'd0, 32'h8011_2233, 1, 0, 32'h102, 32'd0, 4'b0000, 2'd1, 32'hFFFF_8011);
    do_op(3'd6, 32'h202, 32'h0000_ABCD, 32'h0, 0, 0, 32'h202, 32'hABCD_ABCD, 4'b1100, 2'd1, 32'd0);
    check_eq("rdata_hold", dif.rdata, 32'hFFFF_8011);
    do_op(3'd5, 32'h201, 32'h0000_005A, 32'h0, 0, 0, 32'h201, 32'h5A5A_5A5A, 4'b0010, 2'd0, 32'd0);
    do_op(3'd4, 32'h300, 32'd0, 32'h1234_5678, 2, 2, 32'h300, 32'd0, 4'b0000, 2'd2, 32'h1234_5678);
    do_op(3'd7, 32'h400, 32'hCAFE_F00D, 32'h0, 1, 1, 32'h400, 32'hCAFE_F00D, 4'b1111, 2'd2, 32'd0);
    check_eq("rdata_hold2", dif.rdata, 32'h1234_5678);

`ifdef DMEM_ALIGN_CHECK_EN
    do_misalign(3'd4, 32'h102);
    do_misalign(3'd3, 32'h101);
    do_misalign(3'd6, 32'h203);
`else
    do_op(3'd4, 32'h102, 32'd0, 32'hA5A5_0F0F, 0, 0, 32'h100, 32'd0, 4'b0000, 2'd2, 32'hA5A5_0F0F);
    do_op(3'd3, 32'h103, 32'd0, 32'h8001_7FFF, 0, 0, 32'h102, 32'd0, 4'b0000, 2'd1, 32'h0000_8001);
    do_op(3'd6, 32'h201, 32'h0000_1234, 32'h0, 0, 0, 32'h200, 32'h1234_1234, 4'b0011, 2'd1, 32'd0);
    check_eq("noalign_err", dif.addr_err, 32'd0);
`endif

    for (int k = 0; k < 8; k++) begin
      r_op  = 3'($urandom_range(0, 4));
      r_a   = 32'h700 + 32'($urandom_range(0, 15));
      if (r_op == 3'd2 || r_op == 3'd3) r_a[0] = 1'b0;
      if (r_op == 3'd4) r_a[1:0] = 2'b00;
      r_raw = $urandom;
      r_sz  = (r_op <= 3'd1) ? 2'd0 : (r_op <= 3'd3) ? 2'd1 : 2'd2;
      do_op(r_op, r_a, 32'd0, r_raw, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
            r_a, 32'd0, 4'b0000, r_sz, exp_load(r_op, r_a[1:0], r_raw));
    end

    // Reset while waiting for read data, then a stray response.
    do_op(3'd4, 32'h500, 32'd0, 32'h0BAD_CAFE, 0, 0, 32'h500, 32'd0, 4'b0000, 2'd2, 32'h0BAD_CAFE);
    @(posedge clk); #1;
    dif.req_valid = 1'b1; dif.mem_op = 3'd4; dif.addr = 32'h504; dif.d_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    dif.req_valid = 1'b0; dif.d_addr_ok = 1'b1;
    @(posedge clk); #1;
    dif.d_addr_ok = 1'b0;
    @(negedge clk);
    check_eq("rw_wait_stall", dif.stall, 32'd1);
    check_eq("rw_wait_dreq", dif.d_req, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    check_eq("rw_rst_stall", dif.stall, 32'd0);
    check_eq("rw_rst_rdata", dif.rdata, 32'd0);
    check_eq("rw_rst_dreq", dif.d_req, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    dif.d_data_ok = 1'b1;
    @(negedge clk);
    check_eq("stray_rv", dif.rdata_valid, 32'd0);
    check_eq("stray_stall", dif.stall, 32'd0);
    @(posedge clk); #1;
    dif.d_data_ok = 1'b0;
    @(negedge clk);
    check_eq("stray_rv2", dif.rdata_valid, 32'd0);
    check_eq("stray_stall2", dif.stall, 32'd0);
    check_eq("stray_rdata", dif.rdata, 32'd0);

    do_op(3'd4, 32'h600, 32'd0, 32'h600D_F00D, 0, 0, 32'h600, 32'd0, 4'b0000, 2'd2, 32'h600D_F00D);
    check_eq("sb_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected finish before 200000");
    $fatal(1);
  end

endmodule
